// File: rtl/mdunit_pkg.sv
// rtl/mdunit_pkg.sv - shared op and state encodings for the multiply/divide unit
package mdunit_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] MD_IDLE  = 2'd0;
    localparam logic [1:0] MD_RUN   = 2'd1;
    localparam logic [1:0] MD_FIX   = 2'd2;

    function automatic logic mdIsDiv(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic mdIsSigned(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdunit_if.sv
// rtl/mdunit_if.sv - E-stage controller to multiply/divide unit connection
interface mdunit_if #(parameter int WIDTH = 32);
    logic             mdstartE;
    logic [1:0]       mdopE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             hilowriteE;
    logic             hiloselE;
    logic             cancelE;
    logic             stallE;
    logic             mdrunE;
    logic [WIDTH-1:0] hiloutE;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output mdstartE, mdopE, srcaE, srcbE, hilowriteE, hiloselE, cancelE, stallE,
        input  mdrunE, hiloutE, hi, lo
    );

    modport slave (
        input  mdstartE, mdopE, srcaE, srcbE, hilowriteE, hiloselE, cancelE, stallE,
        output mdrunE, hiloutE, hi, lo
    );
endinterface

// File: rtl/mdunit_signfix.sv
// rtl/mdunit_signfix.sv - conditional two's-complement negate (abs when neg is the sign bit)
module md_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);
    assign y = neg ? ((~a) + WIDTH'(1)) : a;
endmodule

// File: rtl/mdunit.sv
// rtl/mdunit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
module mdunit
    import mdunit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    mdunit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      counter;
    logic [WIDTH-1:0]   opReg;
    logic [WIDTH-1:0]   rawA;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic [2*WIDTH-1:0] acc;
    logic               signA;
    logic               signB;
    logic               isDiv;
    logic               divZero;

    logic               signedOp;
    logic               startDiv;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divTrial;
    logic [WIDTH:0]     divDiff;
    logic               qBit;
    logic [2*WIDTH-1:0] accNext;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix;
    logic [WIDTH-1:0]   remFix;

    assign signedOp = mdIsSigned(bus.mdopE);
    assign startDiv = mdIsDiv(bus.mdopE);

    md_signfix #(.WIDTH(WIDTH)) uAbsA (.a(bus.srcaE), .neg(signedOp & bus.srcaE[WIDTH-1]), .y(absA));
    md_signfix #(.WIDTH(WIDTH)) uAbsB (.a(bus.srcbE), .neg(signedOp & bus.srcbE[WIDTH-1]), .y(absB));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifting right.
    // Divide:   acc = {partial remainder, remaining dividend bits / quotient bits}, shifting left.
    assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opReg} : '0);
    assign divTrial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign divDiff  = divTrial - {1'b0, opReg};
    assign qBit     = ~divDiff[WIDTH];

    always_comb begin
        accNext = acc;
        if (isDiv)
            accNext = {(qBit ? divDiff[WIDTH-1:0] : divTrial[WIDTH-1:0]), acc[WIDTH-2:0], qBit};
        else
            accNext = {mulSum, acc[WIDTH-1:1]};
    end

    md_signfix #(.WIDTH(2*WIDTH)) uProd (.a(acc), .neg(signA ^ signB), .y(prodFix));
    md_signfix #(.WIDTH(WIDTH))   uQuot (.a(acc[WIDTH-1:0]), .neg(signA ^ signB), .y(quotFix));
    md_signfix #(.WIDTH(WIDTH))   uRem  (.a(acc[2*WIDTH-1:WIDTH]), .neg(signA), .y(remFix));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MD_IDLE;
            counter <= '0;
            opReg   <= '0;
            rawA    <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            acc     <= '0;
            signA   <= 1'b0;
            signB   <= 1'b0;
            isDiv   <= 1'b0;
            divZero <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (bus.mdstartE && !bus.stallE && !bus.cancelE) begin
                        state   <= MD_RUN;
                        counter <= CW'(WIDTH-1);
                        isDiv   <= startDiv;
                        signA   <= signedOp & bus.srcaE[WIDTH-1];
                        signB   <= signedOp & bus.srcbE[WIDTH-1];
                        rawA    <= bus.srcaE;
                        divZero <= (bus.srcbE == '0);
                        opReg   <= startDiv ? absB : absA;
                        acc     <= {{WIDTH{1'b0}}, (startDiv ? absA : absB)};
                    end else if (bus.hilowriteE && !bus.stallE) begin
                        if (bus.hiloselE)
                            hiReg <= bus.srcaE;
                        else
                            loReg <= bus.srcaE;
                    end
                end
                MD_RUN: begin
                    if (bus.cancelE) begin
                        state <= MD_IDLE;
                    end else begin
                        acc     <= accNext;
                        counter <= counter - CW'(1);
                        if (counter == '0)
                            state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    state <= MD_IDLE;
                    if (!bus.cancelE) begin
                        if (!isDiv) begin
                            hiReg <= prodFix[2*WIDTH-1:WIDTH];
                            loReg <= prodFix[WIDTH-1:0];
                        end else if (divZero) begin
                            hiReg <= rawA;
                            loReg <= '1;
                        end else begin
                            hiReg <= remFix;
                            loReg <= quotFix;
                        end
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign bus.mdrunE  = (state != MD_IDLE);
    assign bus.hi      = hiReg;
    assign bus.lo      = loReg;
    assign bus.hiloutE = bus.hiloselE ? hiReg : loReg;
endmodule

// File: tb/tb_mdunit.sv
// tb/tb_mdunit.sv - directed self-checking bench for mdunit
module tb_mdunit;
    import mdunit_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mdunit_if #(.WIDTH(32)) bus ();

    mdunit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.mdopE = op; bus.srcaE = a; bus.srcbE = b; bus.mdstartE = 1'b1;
        @(negedge clk);
        bus.mdstartE = 1'b0;
    endtask

    task automatic waitDone(output int cyc);
        cyc = 0;
        while (bus.mdrunE && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        startOp(op, a, b);
        waitDone(cyc);
    endtask

    task automatic test_reset;
        checks++; if (bus.mdrunE !== 1'b0) begin errors++; $display("FAIL reset_mdrunE: got %b want 0", bus.mdrunE); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", bus.lo); end
    endtask

    task automatic test_mult;
        int cyc;
        startOp(MD_MULT, 32'hFFFFFFFE, 32'h00000003);
        cyc = 0;
        while (bus.mdrunE && cyc < 100) begin
            cyc++;
            if (cyc == 5) begin
                bus.mdstartE = 1'b1; bus.mdopE = MD_DIVU; bus.srcaE = 32'h9; bus.srcbE = 32'h3;
                bus.hilowriteE = 1'b1; bus.hiloselE = 1'b1;
            end
            if (cyc == 6) begin
                bus.mdstartE = 1'b0; bus.hilowriteE = 1'b0; bus.hiloselE = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (cyc != 33) begin errors++; $display("FAIL mult_run_cycles: got %0d want 33", cyc); end
        checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", bus.lo); end
        checks++; if (bus.hiloutE !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_hiloutE_lo: got %h want fffffffa", bus.hiloutE); end
    endtask

    task automatic test_multu;
        int cyc;
        runOp(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL multu_run_cycles: got %0d want 33", cyc); end
        checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi); end
        checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", bus.lo); end
    endtask

    task automatic test_div;
        int cyc;
        runOp(MD_DIV, 32'hFFFFFFF9, 32'h00000002, cyc);
        checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo: got %h want fffffffd", bus.lo); end
        checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi: got %h want ffffffff", bus.hi); end
        runOp(MD_DIVU, 32'd100, 32'd7, cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL divu_run_cycles: got %0d want 33", cyc); end
        checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want 0000000e", bus.lo); end
        checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 00000002", bus.hi); end
    endtask

    task automatic test_div_zero;
        int cyc;
        runOp(MD_DIVU, 32'h00001234, 32'h0, cyc);
        checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_lo: got %h want ffffffff", bus.lo); end
        checks++; if (bus.hi !== 32'h00001234) begin errors++; $display("FAIL divu0_hi: got %h want 00001234", bus.hi); end
        runOp(MD_DIV, 32'h80000005, 32'h0, cyc);
        checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo: got %h want ffffffff", bus.lo); end
        checks++; if (bus.hi !== 32'h80000005) begin errors++; $display("FAIL div0_hi: got %h want 80000005", bus.hi); end
    endtask

    task automatic test_div_overflow;
        int cyc;
        runOp(MD_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
        checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL divovf_lo: got %h want 80000000", bus.lo); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL divovf_hi: got %h want 00000000", bus.hi); end
    endtask

    task automatic test_cancel_mthi;
        @(negedge clk);
        bus.srcaE = 32'h0BADF00D; bus.hiloselE = 1'b1; bus.hilowriteE = 1'b1;
        @(negedge clk);
        bus.srcaE = 32'hAAAA5555; bus.hiloselE = 1'b0;
        @(negedge clk);
        bus.hilowriteE = 1'b0;
        checks++; if (bus.lo !== 32'hAAAA5555) begin errors++; $display("FAIL mtlo_lo: got %h want aaaa5555", bus.lo); end
        startOp(MD_MULTU, 32'd3, 32'd5);
        bus.hilowriteE = 1'b1; bus.srcaE = 32'h11111111;
        repeat (8) @(negedge clk);
        bus.hilowriteE = 1'b0;
        checks++; if (bus.mdrunE !== 1'b1) begin errors++; $display("FAIL cancel_pre_run: got %b want 1", bus.mdrunE); end
        bus.cancelE = 1'b1;
        @(negedge clk);
        bus.cancelE = 1'b0;
        checks++; if (bus.mdrunE !== 1'b0) begin errors++; $display("FAIL cancel_mdrunE: got %b want 0", bus.mdrunE); end
        repeat (40) @(negedge clk);
        checks++; if (bus.lo !== 32'hAAAA5555) begin errors++; $display("FAIL cancel_lo: got %h want aaaa5555", bus.lo); end
        checks++; if (bus.hi !== 32'h0BADF00D) begin errors++; $display("FAIL cancel_hi: got %h want 0badf00d", bus.hi); end
        bus.srcaE = 32'h12345678; bus.hiloselE = 1'b1; bus.hilowriteE = 1'b1;
        @(negedge clk);
        bus.hilowriteE = 1'b0;
        checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi: got %h want 12345678", bus.hi); end
        checks++; if (bus.hiloutE !== 32'h12345678) begin errors++; $display("FAIL hiloutE_hi: got %h want 12345678", bus.hiloutE); end
        bus.hiloselE = 1'b0;
        #1;
        checks++; if (bus.hiloutE !== 32'hAAAA5555) begin errors++; $display("FAIL hiloutE_lo: got %h want aaaa5555", bus.hiloutE); end
    endtask

    task automatic test_reset_midrun;
        int cyc;
        startOp(MD_MULT, 32'd1000, 32'd1000);
        repeat (14) @(negedge clk);
        checks++; if (bus.mdrunE !== 1'b1) begin errors++; $display("FAIL midrun_pre_run: got %b want 1", bus.mdrunE); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.mdrunE !== 1'b0) begin errors++; $display("FAIL midrun_reset_mdrunE: got %b want 0", bus.mdrunE); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL midrun_reset_hi: got %h want 00000000", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL midrun_reset_lo: got %h want 00000000", bus.lo); end
        @(negedge clk);
        reset = 1'b0;
        runOp(MD_MULT, 32'd6, 32'd7, cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL post_reset_cycles: got %0d want 33", cyc); end
        checks++; if (bus.lo !== 32'd42) begin errors++; $display("FAIL post_reset_lo: got %h want 0000002a", bus.lo); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL post_reset_hi: got %h want 00000000", bus.hi); end
    endtask

    task automatic test_priority;
        int cyc;
        @(negedge clk);
        bus.mdopE = MD_DIVU; bus.srcaE = 32'd50; bus.srcbE = 32'd5;
        bus.mdstartE = 1'b1; bus.hilowriteE = 1'b1; bus.hiloselE = 1'b0;
        @(negedge clk);
        bus.mdstartE = 1'b0; bus.hilowriteE = 1'b0;
        checks++; if (bus.mdrunE !== 1'b1) begin errors++; $display("FAIL start_wins_run: got %b want 1", bus.mdrunE); end
        checks++; if (bus.lo !== 32'd42) begin errors++; $display("FAIL start_wins_nowrite: got %h want 0000002a", bus.lo); end
        waitDone(cyc);
        checks++; if (bus.lo !== 32'd10) begin errors++; $display("FAIL prio_divu_lo: got %h want 0000000a", bus.lo); end
        bus.mdstartE = 1'b1; bus.cancelE = 1'b1;
        @(negedge clk);
        bus.mdstartE = 1'b0; bus.cancelE = 1'b0;
        checks++; if (bus.mdrunE !== 1'b0) begin errors++; $display("FAIL cancel_beats_start: got %b want 0", bus.mdrunE); end
        bus.stallE = 1'b1; bus.mdstartE = 1'b1;
        @(negedge clk);
        bus.mdstartE = 1'b0;
        checks++; if (bus.mdrunE !== 1'b0) begin errors++; $display("FAIL stall_blocks_start: got %b want 0", bus.mdrunE); end
        bus.srcaE = 32'hDEADBEEF; bus.hilowriteE = 1'b1;
        @(negedge clk);
        bus.hilowriteE = 1'b0; bus.stallE = 1'b0;
        checks++; if (bus.lo !== 32'd10) begin errors++; $display("FAIL stall_blocks_write: got %h want 0000000a", bus.lo); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.mdstartE = 1'b0; bus.mdopE = 2'b00; bus.srcaE = '0; bus.srcbE = '0;
        bus.hilowriteE = 1'b0; bus.hiloselE = 1'b0; bus.cancelE = 1'b0; bus.stallE = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        reset = 1'b0;
        test_mult;
        test_multu;
        test_div;
        test_div_zero;
        test_div_overflow;
        test_cancel_mthi;
        test_reset_midrun;
        test_priority;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdunit.md
Name: mdunit

Overview:
- Iterative multiply/divide unit sitting in the Execute stage, directly downstream of the pipeline controller.
- Consumes the controller's E-stage multiply/divide start, op and HI/LO move-to controls, plus ALU source operands.
- Runs MULT/MULTU/DIV/DIVU over WIDTH cycles and owns the HI and LO registers.
- Returns mdrunE to the controller, which uses it to stall HI/LO accesses; supplies HI/LO read data for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mdstartE  in  1  start a multiply/divide using the E-stage operands.
- mdopE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srcaE  in  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO data).
- srcbE  in  WIDTH  rt operand (multiplier/divisor).
- hilowriteE  in  1  MTHI/MTLO write strobe.
- hiloselE  in  1  0 selects LO, 1 selects HI (for both write and read).
- cancelE  in  1  abort an in-flight operation (exception flush).
- stallE  in  1  E stage stalled; suppresses mdstartE and hilowriteE.
- mdrunE  out  1  operation in progress.
- hiloutE  out  WIDTH  HI if hiloselE=1, else LO (combinational).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, active-high): state IDLE, hi=0, lo=0, mdrunE=0, counter=0, all datapath registers 0.
- States: IDLE, RUN, FIX.
- IDLE → RUN on a clock edge with mdstartE=1, stallE=0, cancelE=0.
  - Latch |srca| and |srcb| for signed ops, raw values for unsigned.
  - Latch the sign flags; counter=WIDTH-1.
- RUN, one step per cycle:
  - Multiply: shift-add, 2*WIDTH-bit accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - counter decrements each cycle; RUN → FIX on the edge where counter==0.
- FIX (1 cycle), then → IDLE:
  - Apply signs: negate the product if the signs differ (signed MULT); negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write hi/lo on the FIX → IDLE edge.
  - MULT/MULTU: hi = upper half, lo = lower half.
  - DIV/DIVU: lo = quotient, hi = remainder.
- mdrunE = (state != IDLE).
  - High from the cycle after start for exactly WIDTH+1 cycles (33 at default).
  - New hi/lo are visible the cycle after mdrunE falls.
- Divide by zero, signed or unsigned: lo = all-ones, hi = srcaE as latched at start (raw, not abs). No exception.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (wraparound, no trap).
- cancelE=1 in RUN or FIX: → IDLE on that edge. hi/lo unchanged, mdrunE=0 next cycle.
- cancelE and mdstartE together in IDLE: cancel wins, no start.
- mdstartE while mdrunE=1: ignored (the controller never issues it; the bench checks it is ignored).
- hilowriteE (with stallE=0) in IDLE: write srcaE to hi (hiloselE=1) or lo (hiloselE=0) on the edge.
- hilowriteE while mdrunE=1: ignored; the in-flight result later overwrites both registers.
- mdstartE and hilowriteE together in IDLE: start wins, the write is dropped.
- hiloutE reflects the current registers only; no bypass of in-flight results.

Decomposition:
- Shared package constants:
  - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU op encodings.
  - MD_IDLE/MD_RUN/MD_FIX state encodings.
- One sub-module, md_signfix: combinational two's-complement abs/negate helper, instantiated for operand preparation and result fixup.
- The FSM, counter and accumulator stay in mdunit.

Test Plan:
- MULT srca=0xFFFFFFFE (-2), srcb=0x00000003 → mdrunE high 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 (0xFFFFFFF9, 0x00000002) → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 → lo=14, hi=2.
- DIVU 0x1234/0 → lo=0xFFFFFFFF, hi=0x00001234; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTLO 0xAAAA5555, then start MULTU 3×5, pulse cancelE on cycle 10 → mdrunE drops next cycle; lo=0xAAAA5555, hi unchanged. A subsequent MTHI while idle writes hi and hiloutE follows hiloselE.
- Assert reset mid-RUN (cycle 15) → mdrunE, hi, lo go 0 immediately; after reset release, a new MULT 6×7 gives lo=42, hi=0.
